// File: rtl/gray_pkg.sv
// Shared types and Gray/binary helpers for the Gray counter and its monitor.
// Holds monitor states, default widths and gray2bin / bin2gray.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF  = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_e;

    // Upper bits of a zero-extended code are 0, so the prefix XOR
    // is correct for any width up to 32.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_sync.sv
// WIDTH x STAGES flop chain bringing a Gray bus into the local clock domain.
// Ports: clk, rst_n (async active-low), d (async input), q (last stage).
module gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_d;
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_step_monitor.sv
// Synchronises a Gray count, decodes it and classifies each change as
// up-step, down-step or protocol error (sticky err).
// Ports: clk, reset (async active-low), gray_in, resync, clear,
//        bin_out, valid, step_up, step_down, err.
// Option: GRAY_STEP_MONITOR_ERRCNT_EN adds err_count[7:0], a saturating
//         count of TRACK->FAULT entries cleared only by clear.
module gray_step_monitor
    import gray_pkg::*;
#(
    parameter int data_width  = GRAY_WIDTH_DEF,
    parameter int sync_stages = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] gray_in,
    input  logic                  resync,
    input  logic                  clear,
    output logic [data_width-1:0] bin_out,
    output logic                  valid,
    output logic                  step_up,
    output logic                  step_down,
    output logic                  err
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam int CW = $clog2(sync_stages + 1);
    localparam logic [CW-1:0] FILL = CW'(sync_stages);

    logic [data_width-1:0] s;
    logic [data_width-1:0] b;

    mon_state_e            state_d, state_q;
    logic [CW-1:0]         fill_d, fill_q;
    logic [data_width-1:0] prev_d, prev_q;
    logic [data_width-1:0] bin_d, bin_q;
    logic                  valid_d, valid_q;
    logic                  up_d, up_q;
    logic                  dn_d, dn_q;
    logic                  err_d, err_q;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
    logic [7:0]            ecnt_d, ecnt_q;
`endif

    gray_sync #(
        .WIDTH  (data_width),
        .STAGES (sync_stages)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (gray_in),
        .q     (s)
    );

    assign b = data_width'(gray2bin(32'(s)));

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        valid_d = valid_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        err_d   = err_q;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
        ecnt_d  = ecnt_q;
`endif
        if (clear || resync) begin
            // Re-acquire; this cycle's sample is never classified.
            state_d = ST_ACQUIRE;
            fill_d  = FILL;
            valid_d = 1'b0;
            if (clear) begin
                err_d = 1'b0;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
                ecnt_d = '0;
`endif
            end
        end else begin
            unique case (state_q)
                ST_ACQUIRE: begin
                    valid_d = 1'b0;
                    if (fill_q == '0) begin
                        prev_d  = b;
                        bin_d   = b;
                        valid_d = 1'b1;
                        state_d = ST_TRACK;
                    end else begin
                        fill_d = fill_q - CW'(1);
                    end
                end
                ST_TRACK: begin
                    unique case (1'b1)
                        (b == prev_q): begin
                        end
                        (b == prev_q + data_width'(1)): begin
                            prev_d = b;
                            bin_d  = b;
                            up_d   = 1'b1;
                        end
                        (b == prev_q - data_width'(1)): begin
                            prev_d = b;
                            bin_d  = b;
                            dn_d   = 1'b1;
                        end
                        default: begin
                            prev_d  = b;
                            bin_d   = b;
                            err_d   = 1'b1;
                            state_d = ST_FAULT;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
                            if (ecnt_q != 8'hFF) begin
                                ecnt_d = ecnt_q + 8'd1;
                            end
`endif
                        end
                    endcase
                end
                ST_FAULT: begin
                    prev_d  = b;
                    bin_d   = b;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end
                default: begin
                    state_d = ST_ACQUIRE;
                    fill_d  = FILL;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ACQUIRE;
            fill_q  <= FILL;
            prev_q  <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
            ecnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            err_q   <= err_d;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
            ecnt_q  <= ecnt_d;
`endif
        end
    end

    assign bin_out   = bin_q;
    assign valid     = valid_q;
    assign step_up   = up_q;
    assign step_down = dn_q;
    assign err       = err_q;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
    assign err_count = ecnt_q;
`endif

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed bench for gray_step_monitor (data_width=4, sync_stages=2).
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_gray_step_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] gray_in;
    logic       resync;
    logic       clear;
    logic [3:0] bin_out;
    logic       valid;
    logic       step_up;
    logic       step_down;
    logic       err;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_step_monitor #(
        .data_width  (4),
        .sync_stages (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .resync    (resync),
        .clear     (clear),
        .bin_out   (bin_out),
        .valid     (valid),
        .step_up   (step_up),
        .step_down (step_down),
        .err       (err)
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // New Gray value; result lands 3 edges later and strobes last 1 cycle.
    task automatic step(input string tag, input logic [3:0] g,
                        input logic [3:0] eb, input logic eu,
                        input logic ed, input logic ee);
        gray_in = g;
        tick(2);
        chk({tag, "_pre_up"}, 32'(step_up), 32'd0);
        chk({tag, "_pre_dn"}, 32'(step_down), 32'd0);
        tick(1);
        chk({tag, "_bin"}, 32'(bin_out), 32'(eb));
        chk({tag, "_up"}, 32'(step_up), 32'(eu));
        chk({tag, "_dn"}, 32'(step_down), 32'(ed));
        chk({tag, "_err"}, 32'(err), 32'(ee));
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        tick(1);
        chk({tag, "_up_end"}, 32'(step_up), 32'd0);
        chk({tag, "_dn_end"}, 32'(step_down), 32'd0);
    endtask

    // resync/clear pulse with a new input; valid returns 3 edges later.
    task automatic reacq(input string tag, input logic [3:0] g,
                         input logic r, input logic c,
                         input logic [3:0] eb, input logic ee);
        gray_in = g;
        resync  = r;
        clear   = c;
        tick(1);
        resync  = 1'b0;
        clear   = 1'b0;
        chk({tag, "_valid0"}, 32'(valid), 32'd0);
        chk({tag, "_err0"}, 32'(err), 32'(ee));
        chk({tag, "_up0"}, 32'(step_up), 32'd0);
        chk({tag, "_dn0"}, 32'(step_down), 32'd0);
        tick(2);
        chk({tag, "_valid2"}, 32'(valid), 32'd0);
        tick(1);
        chk({tag, "_valid3"}, 32'(valid), 32'd1);
        chk({tag, "_bin"}, 32'(bin_out), 32'(eb));
        chk({tag, "_err"}, 32'(err), 32'(ee));
    endtask

    initial begin
        reset   = 1'b0;
        gray_in = 4'b0000;
        resync  = 1'b0;
        clear   = 1'b0;
        #12;
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_up", 32'(step_up), 32'd0);
        chk("rst_dn", 32'(step_down), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(2);
        chk("acq_valid_early", 32'(valid), 32'd0);
        tick(1);
        chk("acq_valid", 32'(valid), 32'd1);
        chk("acq_bin", 32'(bin_out), 32'd0);
        chk("acq_up", 32'(step_up), 32'd0);
        chk("acq_err", 32'(err), 32'd0);

        step("up1", 4'b0001, 4'd1, 1'b1, 1'b0, 1'b0);
        step("up2", 4'b0011, 4'd2, 1'b1, 1'b0, 1'b0);
        step("up3", 4'b0010, 4'd3, 1'b1, 1'b0, 1'b0);

        reacq("rs15", 4'b1000, 1'b1, 1'b0, 4'd15, 1'b0);
        step("wrap_up", 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0);
        step("wrap_dn", 4'b1000, 4'd15, 1'b0, 1'b1, 1'b0);
        step("wrap_up2", 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0);

        step("fault7", 4'b0100, 4'd7, 1'b0, 1'b0, 1'b1);
        step("fault_follow", 4'b0101, 4'd6, 1'b0, 1'b0, 1'b1);
        reacq("clr6", 4'b0101, 1'b0, 1'b1, 4'd6, 1'b0);
        step("trk_dn5", 4'b0111, 4'd5, 1'b0, 1'b1, 1'b0);

        reacq("rs2", 4'b0011, 1'b1, 1'b0, 4'd2, 1'b0);
        reacq("rs_jump8", 4'b1100, 1'b1, 1'b0, 4'd8, 1'b0);

        step("fault10", 4'b1111, 4'd10, 1'b0, 1'b0, 1'b1);
        step("fault9", 4'b1101, 4'd9, 1'b0, 1'b0, 1'b1);

        #2;
        reset = 1'b0;
        #1;
        chk("arst_bin", 32'(bin_out), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_up", 32'(step_up), 32'd0);
        chk("arst_dn", 32'(step_down), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(2);
        chk("rel_valid_early", 32'(valid), 32'd0);
        tick(1);
        chk("rel_valid", 32'(valid), 32'd1);
        chk("rel_bin", 32'(bin_out), 32'd9);
        chk("rel_err", 32'(err), 32'd0);

        step("fault0", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
        reacq("clr_and_rs", 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);

`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
        chk("ecnt_start", 32'(err_count), 32'd0);
        step("ec_f1", 4'b0110, 4'd4, 1'b0, 1'b0, 1'b1);
        chk("ecnt_1", 32'(err_count), 32'd1);
        reacq("ec_rs1", 4'b0110, 1'b1, 1'b0, 4'd4, 1'b1);
        step("ec_f2", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
        reacq("ec_rs2", 4'b0000, 1'b1, 1'b0, 4'd0, 1'b1);
        step("ec_f3", 4'b0110, 4'd4, 1'b0, 1'b0, 1'b1);
        chk("ecnt_3", 32'(err_count), 32'd3);
        reacq("ec_clr", 4'b0110, 1'b0, 1'b1, 4'd4, 1'b0);
        chk("ecnt_clr", 32'(err_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
